dm_stage_param: RTL
===================

Name: dm_stage_param

Overview:
- Parametrised data-memory pipeline stage, the next generation of the fixed 16-bit data memory.
- Sits between the execute stage and writeback.
- Takes the execute result (address or ALU value), write data and memory controls, and performs byte-lane writes or reads against an internal RAM with configurable wait states.
- Returns a registered result with a valid pulse, and stalls upstream while an access is in flight.

Parameters:
- DATA_W, 16: data/result width in bits. Must be a multiple of 8.
- ADDR_W, 8: RAM address width. Depth = 2**ADDR_W words.
- WAIT_CYC, 1: extra access cycles per memory op, legal 0..7.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ans_ex  in  DATA_W  execute result. Low ADDR_W bits are the memory address.
- DM_data  in  DATA_W  store data.
- mem_rw_ex  in  1  1 = write, 0 = read.
- mem_en_ex  in  1  1 = memory op this cycle.
- mem_mux_sel_dm  in  1  1 = result is RAM read data, 0 = result is ans_ex.
- be_ex  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i].
- stall_dm  out  1  upstream must hold all inputs while high.
- valid_dm  out  1  one-cycle pulse: ans_dm carries a completed result.
- ans_dm  out  DATA_W  stage result to writeback.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset values: ans_dm=0, valid_dm=0, stall_dm=0, FSM=IDLE, wait counter=0.
- RAM contents are not cleared by reset.
- FSM states:
  - IDLE: no access in flight.
  - WAIT: counting wait cycles, counter 3 bits.
  - Transitions: IDLE->WAIT on mem_en_ex=1 with WAIT_CYC>0. WAIT->IDLE when the counter reaches WAIT_CYC-1.
- Acceptance in IDLE latches addr (ans_ex[ADDR_W-1:0]), ans_ex, DM_data, mem_rw_ex, mem_mux_sel_dm and be_ex.
- Non-memory op (IDLE, mem_en_ex=0):
  - Next edge: ans_dm <= ans_ex, valid_dm <= 1.
  - Latency 1. No stall.
- Memory op accepted in cycle T:
  - stall_dm is high in cycles T..T+WAIT_CYC-1. It is combinational (IDLE & mem_en_ex & WAIT_CYC>0) in cycle T, then registered via WAIT.
  - The RAM operation executes at the rising edge ending cycle T+WAIT_CYC.
  - ans_dm and valid_dm update at that same edge, so the result is visible in cycle T+WAIT_CYC+1.
  - WAIT_CYC=0 gives latency 1 and stall_dm never asserts.
- Read (rw=0):
  - mem_mux_sel_dm=1: ans_dm = RAM[addr].
  - mem_mux_sel_dm=0: ans_dm = latched ans_ex. The RAM is still addressed, with no side effects.
- Write (rw=1):
  - Lane i of RAM[addr] is updated iff be[i]=1. be=0 completes as a no-op write.
  - ans_dm = latched ans_ex, valid_dm pulses.
- Read of an address written by the immediately preceding op returns the new data, since the write completed at an earlier edge.
- valid_dm is 0 in any cycle with no completion. ans_dm holds its last value when valid_dm=0.
- Address wrap: only the low ADDR_W bits of ans_ex are used. Higher bits are ignored for addressing but preserved in pass-through results.
- Input changes while stall_dm=1 are ignored because latched copies are used. Upstream is still required to hold them.
- Back-to-back memory ops:
  - The next op is accepted in the cycle after the previous completion edge, i.e. the FSM returns to IDLE.
  - Throughput is one memory op per WAIT_CYC+1 cycles.
- Reset mid-access: the FSM aborts to IDLE, the pending write is dropped (RAM unchanged), and no valid_dm pulse follows.

Decomposition:
- Shared package dm_pkg holds:
  - the FSM state enum (ST_IDLE, ST_WAIT);
  - the LANES = DATA_W/8 constant function;
  - the MEM_READ/MEM_WRITE encodings of mem_rw_ex.
- One sub-module: dm_bytelane_ram.
  - Parametrised DATA_W/ADDR_W, synchronous write with per-lane enables.
  - Read is asynchronous, sampled into ans_dm by the stage.
- The FSM and result mux live in dm_stage_param.

Test Plan:
- Bench settings: DATA_W=16, ADDR_W=8, WAIT_CYC=2, clk period 10 ns.
- Reset: hold reset=1 for 2 edges -> ans_dm=0x0000, valid_dm=0, stall_dm=0. Then en=0, ans_ex=0x1234 -> next cycle ans_dm=0x1234, valid_dm=1, stall_dm never high.
- Full write then read: write ans_ex=0x0003, DM_data=0xFFFF, be=2'b11 -> stall_dm high 2 cycles, valid_dm at T+3 with ans_dm=0x0003. Then read addr 3, mux_sel=1 -> ans_dm=0xFFFF at T'+3.
- Byte lanes: preload addr 5 = 0xAAAA. Write 0x1234 with be=2'b01 -> read gives 0xAA34. Write with be=2'b00 -> read unchanged 0xAA34.
- Address wrap and pass-through: write 0x5A5A to ans_ex=0x0105 -> read at ans_ex=0x0005 returns 0x5A5A. Read with mux_sel=0 at ans_ex=0x0105 -> ans_dm=0x0105.
- Reset mid-access: start write 0xBEEF to addr 7 (old 0x0000), assert reset in cycle T+1 -> no valid_dm pulse, stall_dm=0 next cycle, later read of addr 7 = 0x0000.
- Stall hold: change DM_data to 0x0000 during stall of a write of 0xC3C3 -> RAM holds 0xC3C3. Issue back-to-back reads -> valid_dm pulses exactly every 3 cycles.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the parametrised data-memory stage.
package dm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } dm_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  function automatic int unsigned lanes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/dm_stage_param_if.sv
// Execute-to-memory handshake bundle: operands and controls in, result and stall out.
interface dm_stage_param_if
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) ();

  localparam int unsigned Lanes = lanes(DATA_W);

  logic [DATA_W-1:0] ans_ex;
  logic [DATA_W-1:0] DM_data;
  logic              mem_rw_ex;
  logic              mem_en_ex;
  logic              mem_mux_sel_dm;
  logic [Lanes-1:0]  be_ex;
  logic              stall_dm;
  logic              valid_dm;
  logic [DATA_W-1:0] ans_dm;

  modport master (
    output ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm, be_ex,
    input  stall_dm, valid_dm, ans_dm
  );

  modport slave (
    input  ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm, be_ex,
    output stall_dm, valid_dm, ans_dm
  );

endinterface

// File: rtl/dm_bytelane_ram.sv
// Word RAM with synchronous per-byte-lane writes and an asynchronous read port.
module dm_bytelane_ram
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [lanes(DATA_W)-1:0]  be_i,
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]         wdata_i,
  output logic [DATA_W-1:0]         rdata_o
);

  localparam int unsigned Lanes = lanes(DATA_W);
  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < Lanes; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dm_stage_param.sv
// Data-memory pipeline stage: latches one memory op, waits WAIT_CYC cycles, then
// performs the RAM access and registers the result with a one-cycle valid pulse.
module dm_stage_param
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic               clk,
  input  logic               reset,
  dm_stage_param_if.slave    bus
);

  localparam int unsigned Lanes   = lanes(DATA_W);
  localparam bit          HasWait = (WAIT_CYC > 0);
  localparam logic [2:0]  LastCnt = HasWait ? 3'(WAIT_CYC - 1) : 3'd0;

  dm_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ans_ex_q, ans_ex_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rw_q, rw_d;
  logic              sel_q, sel_d;
  logic [Lanes-1:0]  be_q, be_d;
  logic [DATA_W-1:0] ans_dm_q, ans_dm_d;
  logic              valid_q, valid_d;

  logic              accept, mem_done, ram_we;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_ans, op_data, ram_rdata;
  logic              op_rw, op_sel;
  logic [Lanes-1:0]  op_be;

  assign accept = (state_q == ST_IDLE) && bus.mem_en_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      ans_dm_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ans_dm_q <= ans_dm_d;
      valid_q  <= valid_d;
    end
  end

  // Operand copies need no reset: they are only consumed after an accept.
  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    ans_ex_q <= ans_ex_d;
    data_q   <= data_d;
    rw_q     <= rw_d;
    sel_q    <= sel_d;
    be_q     <= be_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && HasWait) begin
          state_d = ST_WAIT;
          cnt_d   = 3'd0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LastCnt) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_comb begin
    addr_d   = accept ? bus.ans_ex[ADDR_W-1:0] : addr_q;
    ans_ex_d = accept ? bus.ans_ex         : ans_ex_q;
    data_d   = accept ? bus.DM_data        : data_q;
    rw_d     = accept ? bus.mem_rw_ex      : rw_q;
    sel_d    = accept ? bus.mem_mux_sel_dm : sel_q;
    be_d     = accept ? bus.be_ex          : be_q;

    // With no wait states the access completes on the accepting edge using live inputs.
    op_addr  = HasWait ? addr_q   : bus.ans_ex[ADDR_W-1:0];
    op_ans   = HasWait ? ans_ex_q : bus.ans_ex;
    op_data  = HasWait ? data_q   : bus.DM_data;
    op_rw    = HasWait ? rw_q     : bus.mem_rw_ex;
    op_sel   = HasWait ? sel_q    : bus.mem_mux_sel_dm;
    op_be    = HasWait ? be_q     : bus.be_ex;
    mem_done = HasWait ? ((state_q == ST_WAIT) && (cnt_q == LastCnt)) : accept;
    ram_we   = mem_done && (op_rw == MEM_WRITE) && !reset;
  end

  always_comb begin
    ans_dm_d = ans_dm_q;
    valid_d  = 1'b0;
    if (mem_done) begin
      valid_d  = 1'b1;
      ans_dm_d = ((op_rw == MEM_READ) && op_sel) ? ram_rdata : op_ans;
    end else if ((state_q == ST_IDLE) && !bus.mem_en_ex) begin
      valid_d  = 1'b1;
      ans_dm_d = bus.ans_ex;
    end
  end

  assign bus.stall_dm = (HasWait && accept) || ((state_q == ST_WAIT) && (cnt_q != LastCnt));
  assign bus.valid_dm = valid_q;
  assign bus.ans_dm   = ans_dm_q;

  dm_bytelane_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .be_i    (op_be),
    .addr_i  (op_addr),
    .wdata_i (op_data),
    .rdata_o (ram_rdata)
  );

endmodule
